fetch_queue: RTL
================

# fetch_queue

Decoupling queue between the fetch stage and decode: accepts one {PC, Instr} pair per cycle from fetch and presents the oldest pair to decode with a valid/ready handshake. It absorbs decode stalls without stalling the PC register immediately. It discards all queued work on a control-flow redirect, the same cycle fetch receives PCWrite_F. It is the consuming end of the fetch stage's PC/Instr outputs.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-low reset
- F_Valid  input  1  fetch presents a valid pair this cycle
- PC_F  input  64  PC of the presented instruction
- Instr_F  input  32  instruction word from instruction memory
- F_Ready  output  1  queue can accept a push this cycle; fetch holds PC when low
- Flush  input  1  redirect; asserted together with PCWrite_F
- D_Valid  output  1  head entry valid
- PC_D  output  64  PC of head entry
- Instr_D  output  32  instruction of head entry
- D_Ready  input  1  decode consumes head this cycle
- Count  output  $clog2(DEPTH)+1  current occupancy

## Operation
- Push = F_Valid && F_Ready && !Flush; Pop = D_Valid && D_Ready && !Flush.
- Storage: DEPTH-entry array of {PC, Instr}; write pointer, read pointer, each $clog2(DEPTH) bits, wrap modulo DEPTH naturally; Count tracked separately (DEPTH+1 states: 0..DEPTH).
- Push writes at wr_ptr, wr_ptr+1. Pop advances rd_ptr+1. Count += Push − Pop.
- F_Ready = (Count < DEPTH), combinational from Count only; not a function of D_Ready. Simultaneous push+pop is therefore impossible when full. When full, a pop frees a slot visible the next cycle.
- Simultaneous push and pop when 0<Count<DEPTH: both take effect, Count unchanged.
- D_Valid = (Count != 0). When empty: PC_D = 0, Instr_D = NOP (32'h00000013); otherwise head entry.
- Flush: next cycle wr_ptr = rd_ptr = 0, Count = 0; the push and pop of the flush cycle are both discarded. Decode must not act on a head presented in the flush cycle.
- Flush has priority over everything except reset.
- No fall-through: a pair pushed into an empty queue is not visible at D in the same cycle.

## Timing
- Reset (rst=0 at edge): pointers 0, Count 0 → D_Valid 0, PC_D 0, Instr_D NOP, F_Ready 1 (combinational from reset Count). Storage contents are not reset.
- Reset asserted mid-operation: identical to Flush plus storage don't-care; in-flight pushes are lost.
- Latency push→D_Valid: 1 cycle (push at edge N, visible after edge N).
- Throughput: 1 pair/cycle sustained when D_Ready held high.
- Flush at edge N: D_Valid 0 and F_Ready 1 after edge N. A push at N+1 (new target) is visible after edge N+1.
- Outputs PC_D/Instr_D/D_Valid/F_Ready/Count change only after clock edges; no combinational path from F_Valid/D_Ready to any output.

## Structure
- Shared package riscv_pkg: XLEN=64, ILEN=32, NOP_INSTR=32'h00000013, typedef fetch_pair_t {logic [XLEN-1:0] pc; logic [ILEN-1:0] instr;}.
- One natural sub-module: fetch_queue_mem, a DEPTH×fetch_pair_t flop array with one write port and one asynchronous read port. Pointer/count control stays in fetch_queue.

## Test plan
- Reset then idle: D_Valid 0, Instr_D 00000013, PC_D 0, F_Ready 1, Count 0.
- Push PCs 0,4,8 (instr 00000013, 00500093, 00000013) with D_Ready=0 → Count 3; then D_Ready=1 → pops in order 0,4,8 on consecutive cycles, then D_Valid 0.
- Push 5 pairs with D_Ready=0, DEPTH=4 → F_Ready low after 4th push; 5th ignored, Count 4. One pop → F_Ready 1 next cycle; 5th accepted on retry.
- Continuous push+pop over 10 cycles (PC 0..36) → Count steady at 1, pointer wrap exercised, order preserved, no loss.
- Queue holding 3 entries, Flush with F_Valid=1 and D_Ready=1 → next cycle Count 0, D_Valid 0. Then push PC 40/DEADBEEF → D shows PC 40, Instr DEADBEEF one cycle later.
- rst=0 asserted with Count 2 → next cycle same as reset state; push after release works normally.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath widths, the canonical NOP and the
// {PC, Instr} pair that travels from fetch to decode.
package riscv_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  // addi x0, x0, 0
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_pair_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Storage for the fetch queue: DEPTH flop entries, one synchronous write port
// and one asynchronous read port. Contents are intentionally never reset.
module fetch_queue_mem
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  fetch_pair_t   wdata,
  input  logic [AW-1:0] raddr,
  output fetch_pair_t   rdata
);

  fetch_pair_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Decoupling queue between fetch and decode. Accepts one {PC, Instr} pair per
// cycle, presents the oldest to decode, and drops everything on a redirect.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            F_Valid,
  input  logic [XLEN-1:0] PC_F,
  input  logic [ILEN-1:0] Instr_F,
  output logic            F_Ready,
  input  logic            Flush,
  output logic            D_Valid,
  output logic [XLEN-1:0] PC_D,
  output logic [ILEN-1:0] Instr_D,
  input  logic            D_Ready,
  output logic [AW:0]     Count
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          push;
  logic          pop;
  fetch_pair_t   wr_pair;
  fetch_pair_t   head_pair;

  // Ready depends only on registered occupancy, so a full queue never takes a
  // push even when decode is draining in the same cycle.
  assign F_Ready = (count_q < FULL_COUNT);
  assign D_Valid = (count_q != '0);
  assign Count   = count_q;

  assign push = F_Valid && F_Ready && !Flush;
  assign pop  = D_Valid && D_Ready && !Flush;

  assign wr_pair.pc    = PC_F;
  assign wr_pair.instr = Instr_F;

  fetch_queue_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_pair),
    .raddr (rd_ptr),
    .rdata (head_pair)
  );

  // A flush behaves like reset for the control state; storage is left as is.
  always_ff @(posedge clk) begin
    if (!rst || Flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // Decode sees a harmless NOP at PC 0 whenever nothing is queued.
  assign PC_D    = D_Valid ? head_pair.pc    : '0;
  assign Instr_D = D_Valid ? head_pair.instr : NOP_INSTR;

endmodule
